// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache lookup port among fetch1 walker, memory1 walker and memory0 pipeline.
// Latency: gnt in the issue cycle (dc_read & dc_ready), done in the dc_done cycle, issue-to-issue >= 2 cycles.
// Backpressure: dc_ready low holds the winner's dc_read/dc_addr with no gnt; one lookup outstanding at a time.
// Optional DCARB_RR_EN: fe1/mem1 alternate round-robin instead of fixed mem1 > fe1.
module dcache_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        fe1_req,
  input  logic [28:2] fe1_addr,
  output logic        fe1_gnt,
  output logic        fe1_done,
  input  logic        mem1_req,
  input  logic [28:2] mem1_addr,
  output logic        mem1_gnt,
  output logic        mem1_done,
  input  logic        pipe_req,
  input  logic [31:2] pipe_addr,
  output logic        pipe_gnt,
  output logic        pipe_done,
  input  logic        csr_kill,
  input  logic [31:0] csr_satp,
  output logic        dc_read,
  output logic        dc_trans,
  output logic [8:0]  dc_asid,
  output logic [31:2] dc_addr,
  input  logic        dc_ready,
  input  logic        dc_done,
  output logic        arb_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_FE1  = 2'd0,
    OWN_MEM1 = 2'd1,
    OWN_PIPE = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  owner_t     owner;
  logic [3:0] starve_cnt;

  logic   issue_en;
  logic   pipe_eff;
  logic   pipe_starved;
  logic   walker_pick_mem1;
  logic   win_vld;
  owner_t win_sel;
  logic   issue_fire;
  logic   kill_owned;
  logic   done_fire;
  logic   unused_satp;

  // Issue only from IDLE and never while reset is asserted, so all outputs read 0 in reset.
  assign issue_en     = (state == ST_IDLE) && !reset;
  // A killed pipeline request is invisible to arbitration and to the starvation count.
  assign pipe_eff     = pipe_req && !csr_kill;
  assign pipe_starved = pipe_eff && (starve_cnt == STARVE_LIM);

`ifdef DCARB_RR_EN
  logic rr_mem1;
  assign walker_pick_mem1 = rr_mem1;
`else
  assign walker_pick_mem1 = 1'b1;
`endif

  // Winner selection: starved pipeline first, then walkers, then pipeline.
  always_comb begin
    win_vld = 1'b0;
    win_sel = OWN_FE1;
    if (pipe_starved) begin
      win_vld = 1'b1;
      win_sel = OWN_PIPE;
    end else if (mem1_req && fe1_req) begin
      win_vld = 1'b1;
      win_sel = walker_pick_mem1 ? OWN_MEM1 : OWN_FE1;
    end else if (mem1_req) begin
      win_vld = 1'b1;
      win_sel = OWN_MEM1;
    end else if (fe1_req) begin
      win_vld = 1'b1;
      win_sel = OWN_FE1;
    end else if (pipe_eff) begin
      win_vld = 1'b1;
      win_sel = OWN_PIPE;
    end
  end

  // Lookup steering: walkers issue zero-extended physical addresses, pipeline issues virtual ones.
  always_comb begin
    dc_read  = 1'b0;
    dc_trans = 1'b0;
    dc_addr  = '0;
    if (issue_en && win_vld) begin
      dc_read = 1'b1;
      case (win_sel)
        OWN_FE1:  dc_addr = {3'b000, fe1_addr};
        OWN_MEM1: dc_addr = {3'b000, mem1_addr};
        OWN_PIPE: begin
          dc_addr  = pipe_addr;
          dc_trans = 1'b1;
        end
        default:  dc_addr = '0;
      endcase
    end
  end

  // Grants and dones have to land in the handshake cycle itself, so they are decoded, not registered.
  assign issue_fire = dc_read && dc_ready;
  assign fe1_gnt    = issue_fire && (win_sel == OWN_FE1);
  assign mem1_gnt   = issue_fire && (win_sel == OWN_MEM1);
  assign pipe_gnt   = issue_fire && (win_sel == OWN_PIPE);

  // A kill that coincides with the pipeline's own response swallows that response.
  assign kill_owned = csr_kill && (owner == OWN_PIPE);
  assign done_fire  = (state == ST_WAIT) && dc_done && !reset && !kill_owned;
  assign fe1_done   = done_fire && (owner == OWN_FE1);
  assign mem1_done  = done_fire && (owner == OWN_MEM1);
  assign pipe_done  = done_fire && (owner == OWN_PIPE);

  assign dc_asid     = csr_satp[30:22];
  assign arb_busy    = (state != ST_IDLE);
  assign unused_satp = ^{csr_satp[31], csr_satp[21:0]};

  // Access sequencer: IDLE issues, WAIT returns the response, DRAIN discards a killed pipeline response.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= OWN_FE1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_fire) begin
            owner <= win_sel;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dc_done) begin
            state <= ST_IDLE;
          end else if (kill_owned) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (dc_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Starvation guard: count IDLE cycles a live pipeline request loses, saturating at the limit.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!pipe_req || pipe_gnt) begin
      starve_cnt <= 4'd0;
    end else if ((state == ST_IDLE) && pipe_eff && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef DCARB_RR_EN
  // Round-robin pointer: after a walker is granted, the other walker wins the next tie.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      rr_mem1 <= 1'b1;
    end else if (mem1_gnt) begin
      rr_mem1 <= 1'b0;
    end else if (fe1_gnt) begin
      rr_mem1 <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed vectors, multi-cycle sequences and a randomized run.
// Latency: inputs change on the falling edge, outputs are compared 1 time unit later.
// Backpressure: random dc_ready/dc_done/csr_kill against a transaction-level reference model.
module tb_dcache_port_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef DCARB_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic        clk_core = 1'b0;
  logic        reset;
  logic        fe1_req, mem1_req, pipe_req;
  logic [28:2] fe1_addr, mem1_addr;
  logic [31:2] pipe_addr;
  logic        fe1_gnt, fe1_done, mem1_gnt, mem1_done, pipe_gnt, pipe_done;
  logic        csr_kill;
  logic [31:0] csr_satp;
  logic        dc_read, dc_trans;
  logic [8:0]  dc_asid;
  logic [31:2] dc_addr;
  logic        dc_ready, dc_done, arb_busy;

  dcache_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_core (clk_core),
    .reset    (reset),
    .fe1_req  (fe1_req),
    .fe1_addr (fe1_addr),
    .fe1_gnt  (fe1_gnt),
    .fe1_done (fe1_done),
    .mem1_req (mem1_req),
    .mem1_addr(mem1_addr),
    .mem1_gnt (mem1_gnt),
    .mem1_done(mem1_done),
    .pipe_req (pipe_req),
    .pipe_addr(pipe_addr),
    .pipe_gnt (pipe_gnt),
    .pipe_done(pipe_done),
    .csr_kill (csr_kill),
    .csr_satp (csr_satp),
    .dc_read  (dc_read),
    .dc_trans (dc_trans),
    .dc_asid  (dc_asid),
    .dc_addr  (dc_addr),
    .dc_ready (dc_ready),
    .dc_done  (dc_done),
    .arb_busy (arb_busy)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic        fe1, mem1, pipe, kill, rdy;
    logic [26:0] fa, ma;
    logic [29:0] pa;
    logic [38:0] want;
  } vec_t;

  vec_t vt[10];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state, at transaction level
  bit          m_busy, m_killed, m_fav_mem1;
  int          m_owner, m_loss, win;
  bit          pe, took;
  logic        e_read, e_trans, e_busy;
  logic [29:0] e_addr;
  logic [2:0]  e_gnt, e_done;
  logic [2:0]  prev_gnt;
  logic [2:0]  ord[3];

  // output bundle: read, trans, addr, gnt{fe1,mem1,pipe}, done{fe1,mem1,pipe}, busy
  function automatic logic [38:0] obs_now();
    return {dc_read, dc_trans, dc_addr, fe1_gnt, mem1_gnt, pipe_gnt,
            fe1_done, mem1_done, pipe_done, arb_busy};
  endfunction

  function automatic logic [38:0] mk(input logic rd, input logic tr, input logic [29:0] a,
                                     input logic [2:0] g, input logic [2:0] d, input logic b);
    return {rd, tr, a, g, d, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  task automatic idle_inputs();
    fe1_req = 1'b0; mem1_req = 1'b0; pipe_req = 1'b0;
    fe1_addr = '0; mem1_addr = '0; pipe_addr = '0;
    csr_kill = 1'b0; dc_ready = 1'b0; dc_done = 1'b0; reset = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_core);
  endtask

  task automatic do_reset();
    @(negedge clk_core);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk_core);
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset    = 1'b1;
    csr_satp = 32'h5AC0_0000;

    //            fe1 mem1 pipe kill rdy  fa        ma           pa
    vt[0] = '{0, 0, 0, 0, 1, 27'h0,   27'h0,       30'h0,          mk(0, 0, 30'h0,          3'b000, 3'b000, 0)};
    vt[1] = '{1, 0, 0, 0, 1, 27'h123, 27'h0,       30'h0,          mk(1, 0, 30'h123,        3'b100, 3'b000, 0)};
    vt[2] = '{1, 1, 0, 0, 1, 27'h123, 27'h456,     30'h0,          mk(1, 0, 30'h456,        3'b010, 3'b000, 0)};
    vt[3] = '{0, 0, 1, 0, 1, 27'h0,   27'h0,       30'h0400_0010,  mk(1, 1, 30'h0400_0010,  3'b001, 3'b000, 0)};
    vt[4] = '{0, 0, 1, 1, 1, 27'h0,   27'h0,       30'h0400_0010,  mk(0, 0, 30'h0,          3'b000, 3'b000, 0)};
    vt[5] = '{1, 0, 1, 0, 1, 27'h1,   27'h0,       30'h3FFF_FFFF,  mk(1, 0, 30'h1,          3'b100, 3'b000, 0)};
    vt[6] = '{1, 1, 1, 1, 0, 27'h5,   27'h2AA,     30'h1,          mk(1, 0, 30'h2AA,        3'b000, 3'b000, 0)};
    vt[7] = '{0, 1, 0, 0, 1, 27'h0,   27'h7FF_FFFF, 30'h0,         mk(1, 0, 30'h07FF_FFFF,  3'b010, 3'b000, 0)};
    vt[8] = '{1, 0, 1, 1, 0, 27'h3,   27'h0,       30'h22,         mk(1, 0, 30'h3,          3'b000, 3'b000, 0)};
    vt[9] = '{0, 0, 1, 0, 0, 27'h0,   27'h0,       30'h3FFF_FFFF,  mk(1, 1, 30'h3FFF_FFFF,  3'b000, 3'b000, 0)};

    // reset state
    do_reset();
    #1;
    check("reset_outputs", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 0)));
    check("reset_asid", 64'(dc_asid), 64'(9'h16B));

    // single-cycle arbitration vectors, each from a fresh reset
    for (int i = 0; i < 10; i++) begin
      do_reset();
      fe1_req = vt[i].fe1; mem1_req = vt[i].mem1; pipe_req = vt[i].pipe;
      csr_kill = vt[i].kill; dc_ready = vt[i].rdy;
      fe1_addr = vt[i].fa; mem1_addr = vt[i].ma; pipe_addr = vt[i].pa;
      #1;
      check($sformatf("vec%0d", i), 64'(obs_now()), 64'(vt[i].want));
    end

    // pipeline access with 3-cycle response
    do_reset();
    pipe_req = 1'b1; pipe_addr = 30'h0400_0010; dc_ready = 1'b1;
    #1 check("pipe_c0", 64'(obs_now()), 64'(mk(1, 1, 30'h0400_0010, 3'b001, 3'b000, 0)));
    tick(); pipe_req = 1'b0;
    #1 check("pipe_c1", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 1)));
    tick();
    #1 check("pipe_c2", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 1)));
    tick(); dc_done = 1'b1;
    #1 check("pipe_c3", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b001, 1)));
    tick(); dc_done = 1'b0;
    #1 check("pipe_c4", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 0)));

    // both walkers: mem1 first, fe1 in the cycle after mem1_done
    do_reset();
    fe1_req = 1'b1; mem1_req = 1'b1; fe1_addr = 27'h0123; mem1_addr = 27'h0456; dc_ready = 1'b1;
    #1 check("walk_mem1_gnt", 64'(obs_now()), 64'(mk(1, 0, 30'h456, 3'b010, 3'b000, 0)));
    tick(); mem1_req = 1'b0; dc_done = 1'b1;
    #1 check("walk_mem1_done", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b010, 1)));
    tick(); dc_done = 1'b0;
    #1 check("walk_fe1_gnt", 64'(obs_now()), 64'(mk(1, 0, 30'h123, 3'b100, 3'b000, 0)));
    tick(); fe1_req = 1'b0; dc_done = 1'b1;
    #1 check("walk_fe1_done", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b100, 1)));
    tick(); dc_done = 1'b0;

    // both walkers requesting continuously
    ord[0] = 3'b010;
    ord[1] = RR_ON ? 3'b100 : 3'b010;
    ord[2] = 3'b010;
    fe1_req = 1'b1; mem1_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("walk_pair%0d", k), 64'({fe1_gnt, mem1_gnt, pipe_gnt}), 64'(ord[k]));
      tick(); dc_done = 1'b1;
      tick(); dc_done = 1'b0;
    end

    // starvation guard: mem1 held, pipe wins on the 5th IDLE cycle
    do_reset();
    mem1_req = 1'b1; pipe_req = 1'b1; pipe_addr = 30'h55; dc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("starve_idle%0d", i), 64'({fe1_gnt, mem1_gnt, pipe_gnt}),
               64'((i < 4) ? 3'b010 : 3'b001));
      tick(); if (i == 4) pipe_req = 1'b0; dc_done = 1'b1;
      tick(); dc_done = 1'b0;
    end
    pipe_req = 1'b1;
    #1 check("starve_cleared", 64'({fe1_gnt, mem1_gnt, pipe_gnt}), 64'(3'b010));

    // kill during pipeline WAIT: DRAIN, response discarded
    do_reset();
    pipe_req = 1'b1; pipe_addr = 30'h77; dc_ready = 1'b1;
    #1 check("kill_gnt", 64'({fe1_gnt, mem1_gnt, pipe_gnt}), 64'(3'b001));
    tick(); pipe_req = 1'b0; csr_kill = 1'b1;
    #1 check("kill_wait", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 1)));
    tick(); csr_kill = 1'b0;
    #1 check("kill_drain", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 1)));
    tick(); dc_done = 1'b1;
    #1 check("drain_done", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 1)));
    tick(); dc_done = 1'b0;
    #1 check("drain_idle", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 0)));
    // kill and dc_done together in WAIT
    tick(); pipe_req = 1'b1;
    #1 check("kill2_gnt", 64'({fe1_gnt, mem1_gnt, pipe_gnt}), 64'(3'b001));
    tick(); pipe_req = 1'b0; csr_kill = 1'b1; dc_done = 1'b1;
    #1 check("kill_done_same", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 1)));
    tick(); csr_kill = 1'b0; dc_done = 1'b0;
    #1 check("kill_done_idle", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 0)));
    // kill does not affect a walker's access
    tick(); fe1_req = 1'b1; fe1_addr = 27'h9;
    tick(); fe1_req = 1'b0; csr_kill = 1'b1; dc_done = 1'b1;
    #1 check("kill_walker_done", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b100, 1)));
    tick(); csr_kill = 1'b0; dc_done = 1'b0;

    // dc_ready low: strobe and address held, no grant
    do_reset();
    fe1_req = 1'b1; fe1_addr = 27'h0ABC; dc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("stall%0d", i), 64'(obs_now()), 64'(mk(1, 0, 30'hABC, 3'b000, 3'b000, 0)));
      tick();
    end
    dc_ready = 1'b1;
    #1 check("stall_release", 64'(obs_now()), 64'(mk(1, 0, 30'hABC, 3'b100, 3'b000, 0)));

    // reset in WAIT, late dc_done ignored
    tick(); fe1_req = 1'b0; reset = 1'b1;
    #1 check("rst_wait", 64'({dc_read, fe1_gnt, mem1_gnt, pipe_gnt, fe1_done, mem1_done, pipe_done}), 64'(0));
    tick(); reset = 1'b0; dc_done = 1'b1;
    #1 check("rst_late_done", 64'(obs_now()), 64'(mk(0, 0, 30'h0, 3'b000, 3'b000, 0)));
    tick(); dc_done = 1'b0;

    // randomized run against the transaction-level model
    do_reset();
    m_busy = 0; m_killed = 0; m_fav_mem1 = 1; m_owner = 0; m_loss = 0;
    prev_gnt = 3'b000;
    for (int c = 0; c < 800; c++) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      if (fe1_req && !prev_gnt[2]) begin
        if ($urandom_range(0, 19) == 0) fe1_req = 1'b0;
      end else begin
        fe1_req = ($urandom_range(0, 9) < 4); fe1_addr = 27'($urandom);
      end
      if (mem1_req && !prev_gnt[1]) begin
        if ($urandom_range(0, 19) == 0) mem1_req = 1'b0;
      end else begin
        mem1_req = ($urandom_range(0, 9) < 3); mem1_addr = 27'($urandom);
      end
      if (pipe_req && !prev_gnt[0]) begin
        if ($urandom_range(0, 19) == 0) pipe_req = 1'b0;
      end else begin
        pipe_req = ($urandom_range(0, 9) < 5); pipe_addr = 30'($urandom);
      end
      csr_kill = ($urandom_range(0, 99) < 8);
      dc_ready = ($urandom_range(0, 9) < 7);
      dc_done  = m_busy ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 31) == 0) csr_satp = $urandom;
      #1;

      e_read = 0; e_trans = 0; e_addr = '0; e_gnt = 3'b000; e_done = 3'b000; e_busy = m_busy;
      if (reset) begin
        m_busy = 0; m_killed = 0; m_loss = 0; m_fav_mem1 = 1;
      end else if (!m_busy) begin
        pe  = pipe_req && !csr_kill;
        win = -1;
        if (pe && m_loss >= STARVE_MAX) win = 2;
        else if (mem1_req && fe1_req) win = (RR_ON && !m_fav_mem1) ? 0 : 1;
        else if (mem1_req) win = 1;
        else if (fe1_req) win = 0;
        else if (pe) win = 2;
        if (win >= 0) begin
          e_read  = 1;
          e_trans = (win == 2);
          e_addr  = (win == 0) ? {3'b000, fe1_addr} : (win == 1) ? {3'b000, mem1_addr} : pipe_addr;
        end
        took = (win >= 0) && dc_ready;
        if (took) begin
          e_gnt[2 - win] = 1'b1;
          m_busy = 1; m_owner = win; m_killed = 0;
          if (win != 2) m_fav_mem1 = (win == 0);
        end
        if (!pipe_req || (took && win == 2)) m_loss = 0;
        else if (pe && m_loss < STARVE_MAX) m_loss++;
      end else begin
        if (!pipe_req) m_loss = 0;
        if (dc_done) begin
          if (!m_killed && !(csr_kill && m_owner == 2)) e_done[2 - m_owner] = 1'b1;
          m_busy = 0;
        end else if (csr_kill && m_owner == 2) begin
          m_killed = 1;
        end
      end

      check($sformatf("rand%0d", c), 64'(obs_now()), 64'(mk(e_read, e_trans, e_addr, e_gnt, e_done, e_busy)));
      if (c % 16 == 0) check($sformatf("rand_asid%0d", c), 64'(dc_asid), 64'(csr_satp[30:22]));
      prev_gnt = {fe1_gnt, mem1_gnt, pipe_gnt};
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
